// File: rtl/wdt_supervisor.sv
// Configuration, key-unlock and task check-in aggregation in front of a watchdog timer.
// Optional build macro WDT_SUP_DISABLE_EN lets an unlocked control write return RUN to DISABLED.
module wdt_supervisor #(
    parameter int unsigned            N_TASK     = 4,
    parameter int unsigned            CNT_W      = 24,
    parameter logic [15:0]            KEY        = 16'hA5C3,
    parameter int unsigned            UNLOCK_WIN = 16,
    parameter logic [CNT_W-1:0]       DEF_CNT    = CNT_W'(1000000),
    parameter int unsigned            MIN_CNT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    input  logic [N_TASK-1:0] checkin,
    input  logic              wdt_rst_int,
    output logic              wdt_en,
    output logic              wdt_kick,
    output logic              wdt_ld_en,
    output logic [CNT_W-1:0]  wdt_ld_cnt,
    output logic              unlocked,
    output logic [N_TASK-1:0] task_missing,
    output logic              err_key,
    output logic              err_cfg
);

    localparam int unsigned WIN_W = $clog2(UNLOCK_WIN + 1);

    typedef enum logic {DISABLED, RUN} state_t;

    state_t            state;
    logic [WIN_W-1:0]  win;
    logic [N_TASK-1:0] mask;
    logic [N_TASK-1:0] seen;
    logic              int_q;

    logic              key_wr;
    logic              key_ok;
    logic              cfg_acc;
    logic              cfg_lock;
    logic              ld_bad;
    logic [N_TASK-1:0] mask_new;
    logic [N_TASK-1:0] seen_next;
    logic              done;
    logic              int_rise;

    // Write decode and check-in completion for the current period
    always_comb begin
        key_wr    = cfg_wr && (cfg_addr == 2'd0);
        key_ok    = (cfg_wdata[15:0] == KEY);
        cfg_acc   = cfg_wr && (cfg_addr != 2'd0) && unlocked;
        cfg_lock  = cfg_wr && (cfg_addr != 2'd0) && !unlocked;
        ld_bad    = (cfg_wdata < CNT_W'(MIN_CNT));
        mask_new  = cfg_wdata[N_TASK-1:0];
        seen_next = seen | (checkin & mask);
        done      = (state == RUN) && (seen_next == mask);
        int_rise  = wdt_rst_int && !int_q;
    end

    // Single-process FSM; later assignments in this block take priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DISABLED;
            win          <= '0;
            mask         <= '1;
            seen         <= '0;
            int_q        <= 1'b0;
            wdt_en       <= 1'b0;
            wdt_kick     <= 1'b0;
            wdt_ld_en    <= 1'b0;
            wdt_ld_cnt   <= DEF_CNT;
            unlocked     <= 1'b0;
            task_missing <= '0;
            err_key      <= 1'b0;
            err_cfg      <= 1'b0;
        end else begin
            wdt_kick  <= 1'b0;
            wdt_ld_en <= 1'b0;
            err_key   <= 1'b0;
            err_cfg   <= 1'b0;
            int_q     <= wdt_rst_int;

            if (unlocked) begin
                if (win <= WIN_W'(1)) begin
                    unlocked <= 1'b0;
                    win      <= '0;
                end else begin
                    win <= win - WIN_W'(1);
                end
            end

            if (state == RUN) begin
                if (done) begin
                    seen     <= '0;
                    wdt_kick <= 1'b1;
                end else begin
                    seen <= seen_next;
                end
                if (int_rise) begin
                    task_missing <= mask & ~seen;
                end
            end

            if (key_wr) begin
                if (key_ok) begin
                    unlocked <= 1'b1;
                    win      <= WIN_W'(UNLOCK_WIN);
                end else begin
                    unlocked <= 1'b0;
                    win      <= '0;
                    err_key  <= 1'b1;
                end
            end

            if (cfg_lock) begin
                err_key <= 1'b1;
            end

            // One accepted configuration write per unlock
            if (cfg_acc) begin
                unlocked <= 1'b0;
                win      <= '0;
                case (cfg_addr)
                    2'd1: begin
                        if (ld_bad) begin
                            err_cfg <= 1'b1;
                        end else begin
                            wdt_ld_cnt <= cfg_wdata;
                            wdt_ld_en  <= 1'b1;
                        end
                    end
                    2'd2: begin
                        if (mask_new == '0) begin
                            err_cfg <= 1'b1;
                        end else begin
                            mask     <= mask_new;
                            seen     <= '0;
                            wdt_kick <= 1'b0;
                        end
                    end
                    2'd3: begin
                        if (cfg_wdata[0]) begin
                            if (state == DISABLED) begin
                                state     <= RUN;
                                wdt_en    <= 1'b1;
                                wdt_ld_en <= 1'b1;
                                seen      <= '0;
                            end
                        end else begin
`ifdef WDT_SUP_DISABLE_EN
                            if (state == RUN) begin
                                state    <= DISABLED;
                                wdt_en   <= 1'b0;
                                seen     <= '0;
                                wdt_kick <= 1'b0;
                            end
`else
                            err_cfg <= 1'b1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wdt_supervisor.sv
// Scoreboard bench for wdt_supervisor: stimulus queues expected pulse events, a monitor pops and compares.
module tb_wdt_supervisor;

    localparam int unsigned N_TASK  = 4;
    localparam int unsigned CNT_W   = 24;
    localparam logic [23:0] DEF_CNT = 24'd1000000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_addr = 2'd0;
    logic [CNT_W-1:0]  cfg_wdata = '0;
    logic [N_TASK-1:0] checkin = '0;
    logic              wdt_rst_int = 1'b0;
    logic              wdt_en;
    logic              wdt_kick;
    logic              wdt_ld_en;
    logic [CNT_W-1:0]  wdt_ld_cnt;
    logic              unlocked;
    logic [N_TASK-1:0] task_missing;
    logic              err_key;
    logic              err_cfg;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [28:0] vec;   // {kick, ld_en, err_key, err_cfg, en, ld_cnt}
    } ev_t;

    ev_t exp_q[$];

    wdt_supervisor dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .checkin(checkin), .wdt_rst_int(wdt_rst_int), .wdt_en(wdt_en), .wdt_kick(wdt_kick),
        .wdt_ld_en(wdt_ld_en), .wdt_ld_cnt(wdt_ld_cnt), .unlocked(unlocked),
        .task_missing(task_missing), .err_key(err_key), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    // Monitor: any pulse output is one event, compared against the queue head
    always @(negedge clk) begin
        if (!rst && (wdt_kick || wdt_ld_en || err_key || err_cfg)) begin
            logic [28:0] act;
            ev_t e;
            act = {wdt_kick, wdt_ld_en, err_key, err_cfg, wdt_en, wdt_ld_cnt};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event actual=%h required=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e.vec) begin
                    mismatched++;
                    $display("FAIL %s actual=%h required=%h", e.tag, act, e.vec);
                end
            end
        end
    end

    task automatic expect_ev(input string tag, input logic kick, input logic ld,
                             input logic ek, input logic ec, input logic en,
                             input logic [23:0] cnt);
        ev_t e;
        e.tag = tag;
        e.vec = {kick, ld, ek, ec, en, cnt};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [23:0] d,
                         input logic [3:0] ci);
        cfg_wr    = w;
        cfg_addr  = a;
        cfg_wdata = d;
        checkin   = ci;
        step(1);
        cfg_wr    = 1'b0;
        checkin   = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        drive(1'b1, a, d, 4'b0000);
    endtask

    task automatic ci(input logic [3:0] v);
        drive(1'b0, 2'd0, 24'd0, v);
    endtask

    task automatic key();
        wr(2'd0, 24'h00A5C3);
    endtask

    initial begin
        step(2);
        chk("reset_en", 32'(wdt_en), 32'd0);
        chk("reset_ld_cnt", 32'(wdt_ld_cnt), 32'(DEF_CNT));
        chk("reset_unlocked", 32'(unlocked), 32'd0);
        chk("reset_missing", 32'(task_missing), 32'd0);
        rst = 1'b0;
        step(1);

        expect_ev("locked_ld_write", 0, 0, 1, 0, 0, DEF_CNT);
        wr(2'd1, 24'd50);
        chk("locked_ld_cnt_kept", 32'(wdt_ld_cnt), 32'(DEF_CNT));

        key();
        chk("unlock_open", 32'(unlocked), 32'd1);
        expect_ev("ld_100", 0, 1, 0, 0, 0, 24'd100);
        wr(2'd1, 24'd100);
        chk("relock_after_write", 32'(unlocked), 32'd0);

        key();
        expect_ev("wrong_key", 0, 0, 1, 0, 0, 24'd100);
        wr(2'd0, 24'h001234);
        chk("wrong_key_locks", 32'(unlocked), 32'd0);

        key();
        expect_ev("ld_below_min", 0, 0, 0, 1, 0, 24'd100);
        wr(2'd1, 24'd3);

        key();
        expect_ev("mask_zero", 0, 0, 0, 1, 0, 24'd100);
        wr(2'd2, 24'd0);

        key();
        expect_ev("run_start", 0, 1, 0, 0, 1, 24'd100);
        wr(2'd3, 24'd1);
        chk("run_en", 32'(wdt_en), 32'd1);

        // Mask still all ones: three tasks are not enough, the fourth completes
        ci(4'b0111);
        expect_ev("kick_mask_1111", 1, 0, 0, 0, 1, 24'd100);
        ci(4'b1000);

        key();
        wr(2'd2, 24'd5);
        ci(4'b0001);
        expect_ev("kick_mask_0101", 1, 0, 0, 0, 1, 24'd100);
        ci(4'b0100);
        ci(4'b1010);
        step(2);

        key();
        expect_ev("kick_with_ld", 1, 1, 0, 0, 1, 24'd200);
        drive(1'b1, 2'd1, 24'd200, 4'b0101);

        key();
        drive(1'b1, 2'd2, 24'hF, 4'b0101);
        expect_ev("kick_after_mask_win", 1, 0, 0, 0, 1, 24'd200);
        ci(4'b1111);

        ci(4'b0011);
        wdt_rst_int = 1'b1;
        step(1);
        chk("task_missing", 32'(task_missing), 32'hC);
        wdt_rst_int = 1'b0;
        step(1);

        key();
        step(15);
        chk("window_last_cycle", 32'(unlocked), 32'd1);
        step(1);
        chk("window_expired", 32'(unlocked), 32'd0);
        expect_ev("ctrl_after_expiry", 0, 0, 1, 0, 1, 24'd200);
        wr(2'd3, 24'd1);

        key();
`ifdef WDT_SUP_DISABLE_EN
        wr(2'd3, 24'd0);
        chk("disable_en", 32'(wdt_en), 32'd0);
        ci(4'b1111);
        step(1);
        key();
        expect_ev("rerun", 0, 1, 0, 0, 1, 24'd200);
        wr(2'd3, 24'd1);
`else
        expect_ev("disable_rejected", 0, 0, 0, 1, 1, 24'd200);
        wr(2'd3, 24'd0);
        chk("run_sticky", 32'(wdt_en), 32'd1);
`endif
        step(1);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", 32'(wdt_en), 32'd0);
        chk("async_rst_ld_cnt", 32'(wdt_ld_cnt), 32'(DEF_CNT));
        step(2);
        chk("events_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
